// File: rtl/multi_drive_net_resolver.sv
// multi_drive_net_resolver
//   Clocked golden-model resolver for a multi-driven 4-state net.
//   Value encoding per bit: 00 = 0, 01 = 1, 10 = z, 11 = x.
//   MODE: 0 wire/tri, 1 wand/triand, 2 wor/trior, 3 tri0, 4 tri1, 5 trireg.
//   Trireg bits keep their last value when undriven and decay to x after
//   DECAY_CYCLES clocks (never, when DECAY_CYCLES = 0).
// Ports:
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   drv_i          driver values, driver d bit b at [(d*WIDTH+b)*2 +: 2]
//   drv_valid_i    drv_i is sampled on this edge
//   net_o          registered resolved net
//   net_valid_o    net_o was updated from a sample on the last edge
//   held_o         per-bit trireg charge retention (HOLD), 0 unless MODE = 5
//   decay_pulse_o  one-cycle pulse when any bit decays HOLD -> DECAYED
module multi_drive_net_resolver #(
  parameter int unsigned NUM_DRV      = 4,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned MODE         = 0,
  parameter int unsigned DECAY_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DRV*WIDTH*2-1:0] drv_i,
  input  logic                       drv_valid_i,
  output logic [WIDTH*2-1:0]         net_o,
  output logic                       net_valid_o,
  output logic [WIDTH-1:0]           held_o,
  output logic                       decay_pulse_o
);

  localparam logic [1:0] LV0 = 2'b00;
  localparam logic [1:0] LV1 = 2'b01;
  localparam logic [1:0] LVZ = 2'b10;
  localparam logic [1:0] LVX = 2'b11;

  localparam bit          IS_TRIREG = (MODE == 5);
  localparam int unsigned CW        = (DECAY_CYCLES == 0) ? 1 : $clog2(DECAY_CYCLES + 1);
  localparam logic [1:0]  RST_BIT   = (MODE == 3) ? LV0 :
                                      (MODE == 4) ? LV1 :
                                      (MODE == 5) ? LVX : LVZ;

  if (MODE > 5) begin : g_bad_mode
    $error("multi_drive_net_resolver: unsupported MODE %0d", MODE);
  end

  typedef enum logic [1:0] {
    ST_DRIVEN,
    ST_HOLD,
    ST_DECAYED
  } tr_state_e;

  tr_state_e          st_q  [WIDTH];
  tr_state_e          st_d  [WIDTH];
  logic [CW-1:0]      cnt_q [WIDTH];
  logic [CW-1:0]      cnt_d [WIDTH];
  logic [WIDTH*2-1:0] net_d;
  logic [WIDTH-1:0]   decay_d;
  logic [WIDTH-1:0]   has0, has1, hasx;

  // Per-bit summary of which values appear among the drivers.
  always_comb begin
    has0 = '0;
    has1 = '0;
    hasx = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      for (int unsigned d = 0; d < NUM_DRV; d++) begin
        case (drv_i[(d*WIDTH+b)*2 +: 2])
          LV0:     has0[b] = 1'b1;
          LV1:     has1[b] = 1'b1;
          LVX:     hasx[b] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // All-z result for trireg is never used: that case keeps stored charge.
  function automatic logic [1:0] resolve(input logic h0, input logic h1, input logic hx);
    logic [1:0] r;
    if (MODE == 1)                 r = h0 ? LV0 : hx ? LVX : h1 ? LV1 : LVZ;
    else if (MODE == 2)            r = h1 ? LV1 : hx ? LVX : h0 ? LV0 : LVZ;
    else if (!(h0 || h1 || hx))    r = (MODE == 3) ? LV0 : (MODE == 4) ? LV1 : LVZ;
    else if (hx || (h0 && h1))     r = LVX;
    else                           r = h0 ? LV0 : LV1;
    return r;
  endfunction

  always_comb begin
    net_d   = net_o;
    decay_d = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      st_d[b]  = st_q[b];
      cnt_d[b] = cnt_q[b];
      if (!IS_TRIREG) begin
        if (drv_valid_i) net_d[b*2 +: 2] = resolve(has0[b], has1[b], hasx[b]);
      end else if (drv_valid_i && (has0[b] || has1[b] || hasx[b])) begin
        // A driven sample takes priority over a decay on the same edge.
        net_d[b*2 +: 2] = resolve(has0[b], has1[b], hasx[b]);
        st_d[b]         = ST_DRIVEN;
        cnt_d[b]        = '0;
      end else if (st_q[b] == ST_HOLD) begin
        // Decay fires on the edge where the count would reach DECAY_CYCLES.
        if ((DECAY_CYCLES != 0) && (cnt_q[b] == CW'(DECAY_CYCLES - 1))) begin
          net_d[b*2 +: 2] = LVX;
          st_d[b]         = ST_DECAYED;
          cnt_d[b]        = '0;
          decay_d[b]      = 1'b1;
        end else if (cnt_q[b] != '1) begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end else if (drv_valid_i && (st_q[b] == ST_DRIVEN)) begin
        st_d[b]  = ST_HOLD;
        cnt_d[b] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      net_o         <= {WIDTH{RST_BIT}};
      net_valid_o   <= 1'b0;
      decay_pulse_o <= 1'b0;
      for (int unsigned b = 0; b < WIDTH; b++) begin
        st_q[b]  <= ST_DECAYED;
        cnt_q[b] <= '0;
      end
    end else begin
      net_o         <= net_d;
      net_valid_o   <= drv_valid_i;
      decay_pulse_o <= |decay_d;
      for (int unsigned b = 0; b < WIDTH; b++) begin
        st_q[b]  <= st_d[b];
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  always_comb begin
    held_o = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      held_o[b] = IS_TRIREG && (st_q[b] == ST_HOLD);
    end
  end

endmodule
